// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-lane write-mask constants.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        RESP
    } state_t;

    // Mask bit (3-k) enables byte lane k, so lane 0 sits in mask[3].
    localparam logic [3:0] MASK_B0 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b1100;
    localparam logic [3:0] MASK_H2 = 4'b0011;
    localparam logic [3:0] MASK_W  = 4'b1111;

    function automatic logic [3:0] byte_mask(input logic [1:0] lane);
        return MASK_B0 >> lane;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load alignment: selects the addressed byte/half/word lanes
// from a memory word and zero- or sign-extends the result to 32 bits.
module mem_lsu_align (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);
    import mem_lsu_pkg::*;

    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        b_s     = shifted[7:0];
        h_s     = shifted[15:0];
        data    = shifted;
        case (size)
            SZ_B: begin
                if (sign_ext) data = 32'(b_s);
                else          data = {24'h0, shifted[7:0]};
            end
            SZ_H: begin
                if (sign_ext) data = 32'(h_s);
                else          data = {16'h0, shifted[15:0]};
            end
            // Word accesses only reach memory with lane 0, so shifted == word.
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit in front of a byte-addressed block RAM
// with word-wide read data, lane-masked writes and a bounded read wait.
module mem_lsu #(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic [12:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask
);
    import mem_lsu_pkg::*;

    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [12:0]       addr_p1;
    logic [1:0]        size_p1;
    logic              sgn_p1;
    logic [31:0]       wdata_p1;
    logic [31:0]       rdata_p1;
    logic              err_p1;

    logic              accept;
    logic              req_err;
    logic              rd_timeout;
    logic [31:0]       load_data;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign rd_timeout = (state_q == RWAIT) && !mem_rd_valid && (cnt_q == CNT_LAST);

    always_comb begin
        req_err = (req_addr >= $unsigned(32'(MEM_BYTES)));
        case (req_size)
            SZ_H:    if (req_addr[0])         req_err = 1'b1;
            SZ_W:    if (req_addr[1:0] != 0)  req_err = 1'b1;
            SZ_X:    req_err = 1'b1;
            default: ;
        endcase
    end

    mem_lsu_align u_align (
        .word     (mem_rd_data),
        .lane     (addr_p1[1:0]),
        .size     (size_p1),
        .sign_ext (sgn_p1),
        .data     (load_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        resp_valid  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_mask = '0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) state_d = req_err ? RESP : (req_we ? WR : RD);
            end
            RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = {addr_p1[12:2], 2'b00};
                cnt_d     = '0;
                state_d   = RWAIT;
            end
            RWAIT: begin
                if (mem_rd_valid || rd_timeout) state_d = RESP;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = {addr_p1[12:2], 2'b00};
                case (size_p1)
                    SZ_B: begin
                        mem_wr_data = {4{wdata_p1[7:0]}};
                        mem_wr_mask = byte_mask(addr_p1[1:0]);
                    end
                    SZ_H: begin
                        mem_wr_data = {2{wdata_p1[15:0]}};
                        mem_wr_mask = addr_p1[1] ? MASK_H2 : MASK_H0;
                    end
                    default: begin
                        mem_wr_data = wdata_p1;
                        mem_wr_mask = MASK_W;
                    end
                endcase
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_p1;
                resp_err   = err_p1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: only the FSM and wait counter are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture stage; response data is pre-cleared so errors and
    // stores return zero without extra muxing in RESP.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= req_addr[12:0];
            size_p1  <= req_size;
            sgn_p1   <= req_signed;
            wdata_p1 <= req_wdata;
            err_p1   <= req_err;
            rdata_p1 <= '0;
        end else if (state_q == RWAIT) begin
            if (mem_rd_valid)    rdata_p1 <= load_data;
            else if (rd_timeout) err_p1   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed-vector bench for mem_lsu with a word-wide memory responder and
// queue-based scoreboards for responses and memory strobes.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic [12:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;

    mem_lsu #(.MEM_BYTES(8192), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_mask  (mem_wr_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    resp_t       rsp_q[$];
    wr_t         wr_q[$];
    logic [12:0] rd_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_on = 1'b0;
    logic rd_never = 1'b0;
    logic force_valid = 1'b0;
    logic rd_pend = 1'b0;
    logic [10:0] pend_addr = '0;
    logic [31:0] mem [0:2047];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: read data one cycle after mem_rd_en, masked writes.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            for (int k = 0; k < 4; k++)
                if (mem_wr_mask[3-k]) mem[mem_addr[12:2]][8*k +: 8] = mem_wr_data[8*k +: 8];
        end
        if (rd_pend || force_valid) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem[pend_addr];
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = 32'hDEADBEEF;
        end
        rd_pend = 1'b0;
        if (mem_rd_en && !rd_never) begin
            rd_pend   = 1'b1;
            pend_addr = mem_addr[12:2];
        end
    end

    // Monitor: responses and strobes against the queued expectations.
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        logic [12:0] ra;
        if (mon_on) begin
            if (resp_valid) begin
                if (rsp_q.size() == 0) flag("resp_unexpected");
                else begin
                    r = rsp_q.pop_front();
                    chk("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
                    chk("resp_err", 64'(resp_err), 64'(r.err));
                    chk("resp_latency", 64'(cyc - r.acc + 1), 64'(r.lat));
                end
            end
            if (mem_rd_en) begin
                if (rd_q.size() == 0) flag("rd_strobe_unexpected");
                else begin
                    ra = rd_q.pop_front();
                    chk("rd_addr", 64'(mem_addr), 64'(ra));
                end
            end
            if (mem_wr_en) begin
                if (wr_q.size() == 0) flag("wr_strobe_unexpected");
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(w.addr));
                    chk("wr_data", 64'(mem_wr_data), 64'(w.data));
                    chk("wr_mask", 64'(mem_wr_mask), 64'(w.mask));
                end
            end
            chk("strobe_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
            if (!mem_rd_en && !mem_wr_en)
                chk("idle_bus_zero", 64'({mem_addr, mem_wr_data, mem_wr_mask}), 64'd0);
        end
    end

    task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input logic rd_exp, input logic wr_exp, input logic [12:0] maddr,
                          input logic [31:0] mdata, input logic [3:0] mmask);
        resp_t r;
        wr_t   w;
        logic  seen;
        chk({nm, "_ready"}, 64'(req_ready), 64'd1);
        if (rd_exp) rd_q.push_back(maddr);
        if (wr_exp) begin
            w.addr = maddr; w.data = mdata; w.mask = mmask;
            wr_q.push_back(w);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        r.rdata = exp_rd; r.err = exp_err; r.lat = exp_lat; r.acc = cyc;
        rsp_q.push_back(r);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = addr ^ 32'h0000_0155;
        req_size   = size ^ 2'd1;
        req_signed = ~sgn;
        req_wdata  = ~wdata;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, 64'(req_ready), 64'd0);
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) flag({nm, "_resp_timeout"});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[11'h040] = 32'h80FF7F01;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = '0; req_signed = 1'b0; req_wdata = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        chk("reset_ctrl", 64'({req_ready, resp_valid, resp_err, mem_rd_en, mem_wr_en}), 64'b10000);
        chk("reset_rdata", 64'(resp_rdata), 64'd0);
        rst_n = 1'b1;

        do_req("ldb_s_101",  0, 32'h101, 2'd0, 1, 0, 32'h0000007F, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldb_s_102",  0, 32'h102, 2'd0, 1, 0, 32'hFFFFFFFF, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldb_u_103",  0, 32'h103, 2'd0, 0, 0, 32'h00000080, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldb_s_100",  0, 32'h100, 2'd0, 1, 0, 32'h00000001, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldh_s_102",  0, 32'h102, 2'd1, 1, 0, 32'hFFFF80FF, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldh_u_100",  0, 32'h100, 2'd1, 0, 0, 32'h00007F01, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("ldw_100",    0, 32'h100, 2'd2, 0, 0, 32'h80FF7F01, 0, 3, 1, 0, 13'h100, 0, 0);
        do_req("sth_202",    1, 32'h202, 2'd1, 0, 32'h0000BEEF, 0, 0, 2, 0, 1, 13'h200, 32'hBEEFBEEF, 4'b0011);
        do_req("ldw_200",    0, 32'h200, 2'd2, 0, 0, 32'hBEEF0000, 0, 3, 1, 0, 13'h200, 0, 0);
        do_req("stb_201",    1, 32'h201, 2'd0, 0, 32'h123456A5, 0, 0, 2, 0, 1, 13'h200, 32'hA5A5A5A5, 4'b0100);
        do_req("ldw_200b",   0, 32'h200, 2'd2, 0, 0, 32'hBEEFA500, 0, 3, 1, 0, 13'h200, 0, 0);
        do_req("ldb_s_201",  0, 32'h201, 2'd0, 1, 0, 32'hFFFFFFA5, 0, 3, 1, 0, 13'h200, 0, 0);
        do_req("err_ldw_006", 0, 32'h006, 2'd2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("err_ldw_2000", 0, 32'h2000, 2'd2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("err_ldh_101", 0, 32'h101, 2'd1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("err_sz3_100", 0, 32'h100, 2'd3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("err_stb_2000", 1, 32'h2000, 2'd0, 0, 32'h55, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("err_stw_high", 1, 32'hFFFFFFFC, 2'd2, 0, 32'h55, 0, 1, 1, 0, 0, 0, 0, 0);
        do_req("stw_010",    1, 32'h010, 2'd2, 0, 32'h12345678, 0, 0, 2, 0, 1, 13'h010, 32'h12345678, 4'b1111);
        do_req("ldw_010",    0, 32'h010, 2'd2, 0, 0, 32'h12345678, 0, 3, 1, 0, 13'h010, 0, 0);
        do_req("stw_1ffc",   1, 32'h1FFC, 2'd2, 0, 32'hA1B2C3D4, 0, 0, 2, 0, 1, 13'h1FFC, 32'hA1B2C3D4, 4'b1111);
        do_req("ldb_u_1fff", 0, 32'h1FFF, 2'd0, 0, 0, 32'h000000A1, 0, 3, 1, 0, 13'h1FFC, 0, 0);
        do_req("ldh_s_1ffe", 0, 32'h1FFE, 2'd1, 1, 0, 32'hFFFFA1B2, 0, 3, 1, 0, 13'h1FFC, 0, 0);

        rd_never = 1'b1;
        do_req("ld_timeout", 0, 32'h100, 2'd2, 0, 0, 32'h0, 1, 17, 1, 0, 13'h100, 0, 0);

        // Reset while waiting for read data, then a stray mem_rd_valid.
        chk("rst_ready_pre", 64'(req_ready), 64'd1);
        rd_q.push_back(13'h100);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_signed = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rwait_busy", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready_post", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        force_valid = 1'b0;
        rd_never = 1'b0;
        @(negedge clk);

        do_req("ldw_010_post", 0, 32'h010, 2'd2, 0, 0, 32'h12345678, 0, 3, 1, 0, 13'h010, 0, 0);

        repeat (2) @(negedge clk);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 8192, the byte size of the attached block RAM.
REQ-002 SHALL have parameter TIMEOUT, default 15, the max cycles waited for mem_rd_valid.
REQ-003 SHALL have ports, clock and reset first: clk input 1, rising-edge clock; rst_n input 1, reset, synchronous, active-low.
REQ-004 SHALL have request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_addr in 32 (byte address); req_size in 2 (0=byte, 1=half, 2=word, 3=illegal); req_signed in 1; req_wdata in 32.
REQ-005 SHALL have response ports: resp_valid out 1; resp_rdata out 32; resp_err out 1.
REQ-006 SHALL have memory-side ports: mem_rd_en out 1; mem_addr out 13 (byte address); mem_rd_data in 32; mem_rd_valid in 1; mem_wr_en out 1; mem_wr_data out 32; mem_wr_mask out 4.

Function
REQ-007 SHALL use states IDLE, RD, RWAIT, WR, RESP; req_ready=1 only in IDLE; a request is accepted on an edge with req_valid&req_ready.
REQ-008 SHALL register addr, size, signed and wdata at acceptance; later changes on req_* have no effect until the next acceptance.
REQ-009 SHALL flag error when: size=3; half with addr[0]=1; word with addr[1:0]!=0; or addr >= MEM_BYTES. On error: IDLE->RESP, no memory strobe, resp_err=1, resp_rdata=0.
REQ-010 Load: IDLE->RD; mem_rd_en=1 for exactly one cycle in RD, mem_addr={addr[12:2],2'b00}; then RWAIT.
REQ-011 In RWAIT, SHALL capture mem_rd_data on the cycle mem_rd_valid=1, then go to RESP; mem_rd_valid outside RWAIT is ignored.
REQ-012 SHALL count RWAIT cycles; if the count reaches TIMEOUT without mem_rd_valid, SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-013 Byte lane k (k=addr[1:0]) is bits [8k+7:8k]; mem_wr_mask bit (3-k) enables lane k (mask[3]=bits[7:0], mask[0]=bits[31:24]).
REQ-014 Load result: byte = lane k; half = lanes k,k+1; word = all lanes; zero-extend if req_signed=0, else sign-extend from bit 7/15.
REQ-015 Store: IDLE->WR; mem_wr_en=1 for exactly one cycle in WR; data replicated: byte in all four lanes, half in both halves, word as is; mask: byte 1 bit per REQ-013, half 4'b1100 (k=0) / 4'b0011 (k=2), word 4'b1111; then RESP.
REQ-016 RESP lasts exactly one cycle with resp_valid=1, then IDLE; resp_rdata=0 for stores.
REQ-017 Latency, acceptance at edge N: load with mem_rd_valid one cycle after mem_rd_en -> resp_valid in cycle N+3; store -> cycle N+2; error -> cycle N+1.
REQ-018 mem_rd_en and mem_wr_en SHALL never be high in the same cycle; mem_addr, mem_wr_data and mem_wr_mask are 0 whenever both strobes are low.

Reset
REQ-019 On rst_n=0 at a clock edge: state IDLE, timeout counter 0, all outputs 0 except req_ready=1 from the cycle after reset.
REQ-020 Reset during RD, RWAIT or WR SHALL abandon the access with no response; a late mem_rd_valid after reset is ignored.

Structure
REQ-021 Package mem_lsu_pkg SHALL hold the size encodings (SZ_B/SZ_H/SZ_W), the state enum, and the lane/mask helper constants.
REQ-022 Load alignment and extension (REQ-014) SHALL be a combinational sub-module mem_lsu_align; all other logic stays in mem_lsu.

Verification
REQ-023 Memory word 0x100 = 0x80FF7F01: load byte signed at 0x101 -> resp_rdata 0xFFFFFF7F? no: lane1=0x7F -> 0x0000007F; at 0x102 signed -> 0xFFFFFFFF; at 0x103 unsigned -> 0x00000080.
REQ-024 Store half 0xBEEF at 0x202 -> one-cycle mem_wr_en, mem_addr 0x200, mem_wr_data 0xBEEFBEEF, mask 4'b0011, resp_valid at N+2.
REQ-025 Load word at 0x0006, then at 0x2000 -> both resp_err=1 at N+1, no memory strobes.
REQ-026 Responder never asserts mem_rd_valid -> resp_err=1 after 15 RWAIT cycles, then req_ready=1.
REQ-027 rst_n=0 in RWAIT, then mem_rd_valid=1 -> no resp_valid, req_ready=1 next cycle.
REQ-028 Back-to-back store word 0x12345678 at 0x10, then load word 0x10 -> resp_rdata 0x12345678, req_ready low in every non-IDLE cycle.
